// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port RAM between NREQ
//             requesters. Each access is sequenced IDLE -> ACCESS ->
//             (reads: WAIT x RD_LAT) -> DONE so that RAM read latency is
//             hidden behind a registered req/gnt/done handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        system clock, all state on posedge
//    rst_n      in   1        asynchronous reset, active low
//    req        in   NREQ     request per requester
//    we         in   NREQ     1 = write, 0 = read
//    addr       in   NREQ*AW  requester i at [i*AW +: AW]
//    wdata      in   NREQ*DW  requester i at [i*DW +: DW]
//    lock       in   NREQ     keep ownership for the next transfer
//    gnt        out  NREQ     registered one-hot grant
//    done       out  NREQ     one-cycle completion pulse
//    rdata      out  DW       read data, valid from DONE, held until next read
//    mem_en     out  1        RAM enable
//    mem_we     out  1        RAM write strobe
//    mem_addr   out  AW       RAM address
//    mem_wdata  out  DW       RAM write data
//    mem_rdata  in   DW       RAM read data
// ----------------------------------------------------------------------------
//  Configuration macro
//    MEM_ARB_LOCK_EN : when defined, a requester holding req & lock keeps the
//                      RAM for up to LOCK_MAX back-to-back transfers.
// ============================================================================
module mem_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]    lock,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;

  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
      $error("mem_port_arbiter: RD_LAT must be in 1..3");
    end
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("mem_port_arbiter: NREQ must be in 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;

`ifdef MEM_ARB_LOCK_EN
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);
  // Number of transfers performed under the current ownership (1 after the
  // initial grant from IDLE).
  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = ^{lock, LOCK_MAX[0]};
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: first requesting index after rr_q, with wrap. The loop
  // runs from the farthest offset down so the nearest requester is assigned
  // last and therefore wins.
  // --------------------------------------------------------------------------
  logic             any_req;
  logic [IDX_W-1:0] winner;

  always_comb begin
    int cand;
    any_req = 1'b0;
    winner  = rr_q;
    cand    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        any_req = 1'b1;
        winner  = IDX_W'(cand);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
`ifdef MEM_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          gnt_d   = NREQ'(1) << winner;
          idx_d   = winner;
          rr_d    = winner;
          state_d = S_ACCESS;
`ifdef MEM_ARB_LOCK_EN
          lock_cnt_d = LCNT_W'(1);
`endif
        end
      end
      S_ACCESS: begin
        // A write is committed by the RAM on this cycle's edge.
        if (we[idx_q]) begin
          state_d = S_DONE;
        end else begin
          wait_cnt_d = 2'(RD_LAT);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'd1) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d = '0;
        // Chain straight into another access for the same owner; rr_q already
        // points at this owner, so the forced release re-arbitrates past it.
        if (req[idx_q] && lock[idx_q] && (lock_cnt_q < LCNT_W'(LOCK_MAX))) begin
          state_d    = S_ACCESS;
          gnt_d      = gnt_q;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= IDX_W'(NREQ - 1);
      idx_q      <= '0;
      gnt_q      <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state so reset clears them at once.
  // --------------------------------------------------------------------------
  assign gnt       = gnt_q;
  assign done      = (state_q == S_DONE) ? gnt_q : '0;
  assign rdata     = rdata_q;
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) && we[idx_q];
  assign mem_addr  = (gnt_q != '0) ? addr[int'(idx_q)*AW +: AW]  : '0;
  assign mem_wdata = (gnt_q != '0) ? wdata[int'(idx_q)*DW +: DW] : '0;

endmodule
`default_nettype wire
